afu_writeback_engine: RTL
=========================

// Module: afu_writeback_engine
// PURPOSE
//  Reader end of afu_user's output FIFO. Pops 512-bit result lines (e.g. transposed
//  matrix rows) when the FIFO is non-empty and issues them as host-memory write
//  requests at consecutive cache-line addresses base_addr, base_addr+1, ...
//  A start pulse launches a job of num_lines lines; done is raised once every line is accepted.
// PARAMETERS
//  LINE_WIDTH  512  data bits per line (fixed by the afu_user FIFO interface)
//  ADDR_WIDTH  32   cache-line address width
//  CNT_WIDTH   16   line-count width (max job = 2^CNT_WIDTH-1 lines)
//  BUF_DEPTH   4    holding-buffer entries; power of two, >=3
// PORTS
//  clk                in   1          single clock, all logic rising-edge
//  reset              in   1          asynchronous, active-low reset
//  start              in   1          1-cycle job launch; ignored while busy
//  base_addr          in   ADDR_WIDTH first line address, sampled on start
//  num_lines          in   CNT_WIDTH  lines in job, sampled on start
//  busy               out  1          job in progress
//  done               out  1          job complete; held until next accepted start
//  output_fifo_dout   in   LINE_WIDTH FIFO read data, valid the cycle after re
//  output_fifo_empty  in   1          FIFO empty flag
//  output_fifo_re     out  1          FIFO pop strobe
//  wr_req_valid       out  1          write request valid
//  wr_req_ready       in   1          host accepts request when valid&&ready
//  wr_req_addr        out  ADDR_WIDTH line address of request
//  wr_req_data        out  LINE_WIDTH line data of request
//  stall_cycles       out  32         only with AFU_WB_PERF_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset==0): all outputs 0, state IDLE, counters/pointers cleared, buffer empty.
//  FSM: IDLE -start-> RUN; RUN -(sent_cnt==num_lines)-> DONE; DONE -start-> RUN.
//   start with num_lines==0: IDLE/DONE -> DONE next cycle; no re, no request.
//   busy=1 only in RUN; done=1 only in DONE.
//  Read: output_fifo_re=1 in cycle N iff RUN && !output_fifo_empty &&
//   read_cnt<num_lines && (occupancy+inflight)<BUF_DEPTH-1. Registered output; no
//   combinational path from wr_req_ready or output_fifo_empty to re.
//   Data captured into buffer at the end of cycle N+1; inflight is 0/1.
//  Write: wr_req_valid=1 whenever buffer non-empty; addr = base_addr+sent_cnt
//   (modulo 2^ADDR_WIDTH wrap). valid/addr/data held stable until valid&&ready.
//   On acceptance: pop entry, sent_cnt++.
//  Latency: start@0 -> RUN@1 -> earliest re@1 -> earliest wr_req_valid@3.
//  Throughput: 1 line/cycle sustained when FIFO non-empty and ready held high.
//  Simultaneous capture and pop in one cycle: occupancy unchanged, order kept.
//  Never pops more than num_lines lines from the FIFO; buffer never overflows.
//  start while busy: ignored, no parameter resample.
//  Reset mid-job: immediate abort, buffered/in-flight lines dropped; FIFO owner resets too.
// CONFIGURATION
//  AFU_WB_PERF_EN defined: stall_cycles counts RUN cycles with wr_req_valid&&!wr_req_ready.
//   Cleared on reset and on accepted start; saturates at 2^32-1.
//  Undefined: no stall_cycles port, no counter logic.
// STRUCTURE
//  Package afu_wb_pkg: LINE_WIDTH constant, FSM state typedef {IDLE,RUN,DONE}.
//  Sub-module afu_wb_line_buf: BUF_DEPTH x LINE_WIDTH circular buffer with
//   push/pop/occupancy and wrapping pointers. Top module holds FSM, counters, read gating.
// TESTING
//  1 base=0x100,num=4, FIFO preloaded 4 lines, ready=1 -> addrs 0x100..0x103 in order,
//    data match, re exactly 4 cycles, done@ after last accept, busy low.
//  2 num=8, ready toggles 1/0 each cycle -> no data loss/duplication, valid/data stable
//    while ready=0, never >BUF_DEPTH-1 lines unconsumed.
//  3 num=3, FIFO holds 5 lines -> exactly 3 pops, 2 lines remain in FIFO.
//  4 num=0 start -> done next cycle, re and wr_req_valid stay 0.
//  5 base=0xFFFFFFFE,num=4 -> addrs FFFFFFFE,FFFFFFFF,0,1; second start mid-job ignored.
//  6 reset asserted mid-job (2 of 6 sent) -> all outputs 0 asynchronously; new job runs clean.

Source files
------------

// File: rtl/afu_wb_pkg.sv
// Shared constants and types for the AFU write-back engine.
// Optional stall counter is enabled with the AFU_WB_PERF_EN macro.
package afu_wb_pkg;

    localparam int LINE_WIDTH = 512;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wb_state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (&value) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/afu_wb_line_buf.sv
// Small circular holding buffer between the FIFO read port and the write-request port.
// Head entry is presented combinationally so a request can issue the cycle after capture.
module afu_wb_line_buf
    import afu_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = LINE_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_head_data,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;

    // Storage carries no reset; the head is only meaningful while occupancy is non-zero.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_occ <= r_occ + OCC_W'(i_push) - OCC_W'(i_pop);
        end
    end

    assign o_head_data = r_mem[r_rd_ptr];
    assign o_empty     = (r_occ == '0);
    assign o_occupancy = r_occ;

endmodule

// File: rtl/afu_writeback_engine.sv
// Drains afu_user's output FIFO and issues lines as host writes at consecutive addresses.
// Define AFU_WB_PERF_EN to add the stall_cycles counter port.
module afu_writeback_engine
    import afu_wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int BUF_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  num_lines,
    output logic                  busy,
    output logic                  done,
    input  logic [LINE_WIDTH-1:0] output_fifo_dout,
    input  logic                  output_fifo_empty,
    output logic                  output_fifo_re,
    output logic                  wr_req_valid,
    input  logic                  wr_req_ready,
    output logic [ADDR_WIDTH-1:0] wr_req_addr,
    output logic [LINE_WIDTH-1:0] wr_req_data
`ifdef AFU_WB_PERF_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    localparam int OCC_W = $clog2(BUF_DEPTH) + 1;

    wb_state_t             r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [CNT_WIDTH-1:0]  r_num;
    logic [CNT_WIDTH-1:0]  r_read_cnt;
    logic [CNT_WIDTH-1:0]  r_sent_cnt;
    logic                  r_re;
    logic                  r_inflight;

    wb_state_t             w_state_next;
    logic                  w_start_acc;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_buf_empty;
    logic [OCC_W-1:0]      w_occ;
    logic [OCC_W-1:0]      w_occ_next;
    logic [OCC_W:0]        w_pending;
    logic [CNT_WIDTH-1:0]  w_sent_next;
    logic [CNT_WIDTH-1:0]  w_read_next;
    logic [CNT_WIDTH-1:0]  w_num_next;
    logic                  w_re_next;
    logic [LINE_WIDTH-1:0] w_head_data;

    afu_wb_line_buf #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (LINE_WIDTH)
    ) u_line_buf (
        .clk         (clk),
        .rst_n       (reset),
        .i_push      (w_push),
        .i_push_data (output_fifo_dout),
        .i_pop       (w_pop),
        .o_head_data (w_head_data),
        .o_empty     (w_buf_empty),
        .o_occupancy (w_occ)
    );

    always_comb begin
        w_start_acc  = start && (r_state != RUN);
        w_push       = r_inflight;
        w_pop        = !w_buf_empty && wr_req_ready;
        w_sent_next  = w_start_acc ? '0 : r_sent_cnt + CNT_WIDTH'(w_pop);
        w_read_next  = w_start_acc ? '0 : r_read_cnt + CNT_WIDTH'(r_re);
        w_num_next   = w_start_acc ? num_lines : r_num;
        w_occ_next   = w_occ + OCC_W'(w_push) - OCC_W'(w_pop);

        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_next = (num_lines == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_sent_next == r_num) begin
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase

        // Next cycle's occupancy plus the line popped this cycle (still in flight next cycle).
        w_pending = {1'b0, w_occ_next} + (OCC_W + 1)'(r_re);
        w_re_next = (w_state_next == RUN) && !output_fifo_empty &&
                    (w_read_next < w_num_next) &&
                    (w_pending < (OCC_W + 1)'(BUF_DEPTH - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_base     <= '0;
            r_num      <= '0;
            r_read_cnt <= '0;
            r_sent_cnt <= '0;
            r_re       <= 1'b0;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            if (w_start_acc) begin
                r_base <= base_addr;
            end
            r_num      <= w_num_next;
            r_read_cnt <= w_read_next;
            r_sent_cnt <= w_sent_next;
            r_re       <= w_re_next;
            r_inflight <= r_re;
        end
    end

    assign busy           = (r_state == RUN);
    assign done           = (r_state == DONE);
    assign output_fifo_re = r_re;
    assign wr_req_valid   = !w_buf_empty;
    assign wr_req_addr    = r_base + ADDR_WIDTH'(r_sent_cnt);
    assign wr_req_data    = wr_req_valid ? w_head_data : '0;

`ifdef AFU_WB_PERF_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cycles <= '0;
        end else if (w_start_acc) begin
            r_stall_cycles <= '0;
        end else if ((r_state == RUN) && wr_req_valid && !wr_req_ready) begin
            r_stall_cycles <= sat_inc32(r_stall_cycles);
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule
